uart_hex_printer: RTL and testbench

Upstream feeder for the byte-wide UART transmitter. Accepts one DATA_WIDTH-bit word per handshake and sends it as ASCII hex, MSB nibble first, with an optional "0x" prefix and terminator. Drives the transmitter's din/wr_en and paces itself on its tx_busy. Used to dump PSRAM readback words and test results to the host terminal.

---
 rtl/uart_hex_printer.sv | 149 ++++++++++++++
 tb/tb_uart_hex_printer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_printer.sv
// Feeds a byte-wide UART transmitter with one word rendered as ASCII hex,
// optionally wrapped in a "0x" prefix and a space or CR LF terminator.
module uart_hex_printer #(
  parameter int DATA_WIDTH = 32,
  parameter int PREFIX     = 1,
  parameter int TERM       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_wr_en,
  input  logic                  tx_busy,
  output logic                  busy
);

  localparam int NPFX  = (PREFIX != 0) ? 2 : 0;
  localparam int ND    = DATA_WIDTH / 4;
  localparam int NTRM  = (TERM == 1) ? 1 : ((TERM == 2) ? 2 : 0);
  localparam int N     = NPFX + ND + NTRM;
  localparam int IDX_W = $clog2(N + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SEND, S_GUARD, S_WAIT} state_t;

  state_t                  state_r;
  logic [IDX_W-1:0]        idx_r;
  logic [DATA_WIDTH-1:0]   word_r;
  logic [7:0]              tx_data_r;
  logic                    tx_wr_en_r;
  logic                    busy_r;

  logic [IDX_W-1:0]        sel_idx_s;
  logic [DATA_WIDTH-1:0]   sel_word_s;
  logic [DATA_WIDTH-1:0]   next_word_s;
  logic [7:0]              next_char_s;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    logic [7:0] c;
    if (nib < 4'd10) c = 8'h30 + {4'h0, nib};
    else             c = 8'h37 + {4'h0, nib};
    return c;
  endfunction

  function automatic logic is_digit(input logic [IDX_W-1:0] idx);
    return (int'(idx) >= NPFX) && (int'(idx) < NPFX + ND);
  endfunction

  function automatic logic [7:0] char_at(input logic [IDX_W-1:0] idx, input logic [3:0] nib);
    logic [7:0] c;
    int         pos;
    pos = int'(idx);
    if (pos < NPFX)           c = (pos == 0) ? 8'h30 : 8'h78;
    else if (pos < NPFX + ND) c = hex_ascii(nib);
    else if (TERM == 2)       c = (pos == NPFX + ND) ? 8'h0D : 8'h0A;
    else if (TERM == 1)       c = 8'h20;
    else                      c = 8'h00;
    return c;
  endfunction

  // Character about to be loaded on the next SEND entry; digits come from the top nibble.
  always_comb begin
    sel_idx_s   = {IDX_W{1'b0}};
    sel_word_s  = word_r;
    next_word_s = word_r;
    next_char_s = 8'h00;
    if (state_r == S_WAIT) sel_idx_s = idx_r + IDX_W'(1);
    else                   sel_idx_s = {IDX_W{1'b0}};
    if (state_r == S_IDLE) sel_word_s = in_data;
    else                   sel_word_s = word_r;
    next_char_s = char_at(sel_idx_s, sel_word_s[DATA_WIDTH-1 -: 4]);
    if (is_digit(sel_idx_s)) next_word_s = sel_word_s << 4'd4;
    else                     next_word_s = sel_word_s;
  end

  // Sequencer: SEND strobes once, GUARD covers the transmitter's wr_en-to-busy delay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      idx_r      <= {IDX_W{1'b0}};
      word_r     <= {DATA_WIDTH{1'b0}};
      tx_data_r  <= 8'h00;
      tx_wr_en_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          tx_wr_en_r <= 1'b0;
          if (in_valid) begin
            busy_r <= 1'b1;
            idx_r  <= {IDX_W{1'b0}};
            if (!tx_busy) begin
              state_r    <= S_SEND;
              tx_wr_en_r <= 1'b1;
              tx_data_r  <= next_char_s;
              word_r     <= next_word_s;
            end else begin
              state_r <= S_PRE;
              word_r  <= in_data;
            end
          end
        end
        S_PRE: begin
          if (!tx_busy) begin
            state_r    <= S_SEND;
            tx_wr_en_r <= 1'b1;
            tx_data_r  <= next_char_s;
            word_r     <= next_word_s;
          end
        end
        S_SEND: begin
          tx_wr_en_r <= 1'b0;
          state_r    <= S_GUARD;
        end
        S_GUARD: begin
          state_r <= S_WAIT;
        end
        S_WAIT: begin
          if (!tx_busy) begin
            if (idx_r == LAST_IDX) begin
              state_r <= S_IDLE;
              busy_r  <= 1'b0;
            end else begin
              idx_r      <= sel_idx_s;
              state_r    <= S_SEND;
              tx_wr_en_r <= 1'b1;
              tx_data_r  <= next_char_s;
              word_r     <= next_word_s;
            end
          end
        end
        default: begin
          state_r    <= S_IDLE;
          idx_r      <= {IDX_W{1'b0}};
          tx_wr_en_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign tx_data  = tx_data_r;
  assign tx_wr_en = tx_wr_en_r;
  assign busy     = busy_r;
  assign in_ready = !busy_r && !rst;

endmodule

// File: tb/tb_uart_hex_printer.sv
// Scoreboard bench: two printer configurations, each paced by a simple UART busy model.
module tb_uart_hex_printer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] a_in_data;
  logic        a_in_valid, a_in_ready, a_wr, a_busy, a_txb;
  logic [7:0]  a_data;
  logic [7:0]  b_in_data;
  logic        b_in_valid, b_in_ready, b_wr, b_busy, b_txb;
  logic [7:0]  b_data;

  uart_hex_printer u_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .tx_data(a_data), .tx_wr_en(a_wr), .tx_busy(a_txb), .busy(a_busy));

  uart_hex_printer #(.DATA_WIDTH(8), .PREFIX(0), .TERM(1)) u_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .tx_data(b_data), .tx_wr_en(b_wr), .tx_busy(b_txb), .busy(b_busy));

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] sb_a[$];
  logic [7:0] sb_b[$];
  int         remain[2];
  int         nstb[2];
  int         busy_cycles[2];
  logic       prev_wr[2];
  logic [7:0] last_data[2];

  localparam logic [7:0] DEADBEEF_B [12] = '{8'h30, 8'h78, 8'h44, 8'h45, 8'h41, 8'h44,
                                             8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
  localparam logic [7:0] ONE_B [12]      = '{8'h30, 8'h78, 8'h30, 8'h30, 8'h30, 8'h30,
                                             8'h30, 8'h30, 8'h30, 8'h31, 8'h0D, 8'h0A};
  localparam logic [7:0] B_BYTES [6]     = '{8'h30, 8'h30, 8'h20, 8'h39, 8'h46, 8'h20};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
  endfunction

  task automatic push_a_word(input logic [31:0] w);
    sb_a.push_back(8'h30);
    sb_a.push_back(8'h78);
    for (int i = 7; i >= 0; i--) sb_a.push_back(hexc(w[4*i +: 4]));
    sb_a.push_back(8'h0D);
    sb_a.push_back(8'h0A);
  endtask

  // Monitor plus UART model for one printer, evaluated once per falling edge.
  task automatic mon(input int u, input logic wr, input logic [7:0] d, input logic dbusy,
                     input logic txb, output logic txb_next);
    logic [7:0] e;
    logic       has;
    e = 8'h00;
    has = 1'b0;
    if (wr === 1'b1) begin
      nstb[u]++;
      chk(u == 0 ? "a_strobe_while_tx_busy" : "b_strobe_while_tx_busy", 64'(txb), 64'(1'b0));
      chk(u == 0 ? "a_strobe_width" : "b_strobe_width", 64'(prev_wr[u]), 64'(1'b0));
      if (u == 0) begin
        has = (sb_a.size() != 0);
        if (has) e = sb_a.pop_front();
      end else begin
        has = (sb_b.size() != 0);
        if (has) e = sb_b.pop_front();
      end
      chk(u == 0 ? "a_byte_pending" : "b_byte_pending", 64'(has), 64'(1'b1));
      if (has) chk(u == 0 ? "a_byte" : "b_byte", 64'(d), 64'(e));
      last_data[u] = d;
      remain[u] = busy_cycles[u];
    end else if (dbusy === 1'b1) begin
      chk(u == 0 ? "a_tx_data_stable" : "b_tx_data_stable", 64'(d), 64'(last_data[u]));
    end
    prev_wr[u] = wr;
    txb_next = (remain[u] > 0);
    if (remain[u] > 0) remain[u]--;
  endtask

  initial begin
    logic nb;
    a_txb = 1'b0;
    b_txb = 1'b0;
    forever begin
      @(negedge clk);
      mon(0, a_wr, a_data, a_busy, a_txb, nb);
      a_txb = nb;
      mon(1, b_wr, b_data, b_busy, b_txb, nb);
      b_txb = nb;
    end
  end

  task automatic offer_a(input logic [31:0] w);
    logic txb0;
    int   t;
    t = 0;
    @(negedge clk); #1;
    while (a_in_ready !== 1'b1 && t < 2000) begin
      @(negedge clk); #1;
      t++;
    end
    chk("a_ready_wait", 64'(a_in_ready), 64'(1'b1));
    a_in_data  = w;
    a_in_valid = 1'b1;
    txb0 = a_txb;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    chk("a_accept_busy", 64'(a_busy), 64'(1'b1));
    @(negedge clk); #1;
    if (txb0 === 1'b0) chk("a_first_strobe_latency", 64'(a_wr), 64'(1'b1));
  endtask

  task automatic wait_idle(input int u, input int limit);
    int   t;
    logic idle;
    t = 0;
    idle = 1'b0;
    while (!idle && t < limit) begin
      @(negedge clk); #1;
      t++;
      if (u == 0) idle = (a_busy === 1'b0) && (sb_a.size() == 0);
      else        idle = (b_busy === 1'b0) && (sb_b.size() == 0);
    end
    chk(u == 0 ? "a_idle_timeout" : "b_idle_timeout", 64'(idle), 64'(1'b1));
  endtask

  task automatic wait_strobes(input int target, input int limit);
    int t;
    t = 0;
    while (nstb[0] < target && t < limit) begin
      @(negedge clk); #1;
      t++;
    end
    chk("a_strobe_wait", 64'(nstb[0] >= target), 64'(1'b1));
  endtask

  initial begin
    int base;
    int t;
    rst = 1'b1;
    a_in_data = 32'h0; a_in_valid = 1'b0;
    b_in_data = 8'h0;  b_in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      remain[i] = 0; nstb[i] = 0; busy_cycles[i] = 10; prev_wr[i] = 1'b0; last_data[i] = 8'h00;
    end

    // reset defaults
    repeat (5) @(negedge clk);
    #1;
    chk("rst_a_wr", 64'(a_wr), 64'(1'b0));
    chk("rst_a_data", 64'(a_data), 64'(8'h00));
    chk("rst_a_busy", 64'(a_busy), 64'(1'b0));
    chk("rst_b_wr", 64'(b_wr), 64'(1'b0));
    chk("rst_b_busy", 64'(b_busy), 64'(1'b0));
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rel_a_ready", 64'(a_in_ready), 64'(1'b1));
    chk("rel_b_ready", 64'(b_in_ready), 64'(1'b1));
    repeat (10) @(negedge clk);
    #1;
    chk("idle_no_strobe_a", 64'(nstb[0]), 64'(0));
    chk("idle_no_strobe_b", 64'(nstb[1]), 64'(0));

    // DEADBEEF with default parameters
    foreach (DEADBEEF_B[i]) sb_a.push_back(DEADBEEF_B[i]);
    offer_a(32'hDEADBEEF);
    wait_idle(0, 1000);
    chk("deadbeef_strobes", 64'(nstb[0]), 64'(12));
    chk("deadbeef_busy_low", 64'(a_busy), 64'(1'b0));

    // 8-bit, no prefix, space terminator, back-to-back words
    foreach (B_BYTES[i]) sb_b.push_back(B_BYTES[i]);
    @(negedge clk); #1;
    b_in_data  = 8'h00;
    b_in_valid = 1'b1;
    @(posedge clk); #1;
    chk("b_first_accept", 64'(b_busy), 64'(1'b1));
    chk("b_ready_low", 64'(b_in_ready), 64'(1'b0));
    b_in_data = 8'h9F;
    t = 0;
    while (b_in_ready !== 1'b1 && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("b_ready_returns", 64'(b_in_ready), 64'(1'b1));
    @(posedge clk); #1;
    chk("b_second_accept_no_gap", 64'(b_busy), 64'(1'b1));
    b_in_valid = 1'b0;
    @(negedge clk); #1;
    chk("b_second_first_strobe", 64'(b_wr), 64'(1'b1));
    wait_idle(1, 1000);
    chk("b_strobes", 64'(nstb[1]), 64'(6));

    // slow transmitter pacing, plus a word offered while busy that must be dropped
    busy_cycles[0] = 1000;
    base = nstb[0];
    push_a_word(32'h0123ABCD);
    offer_a(32'h0123ABCD);
    wait_strobes(base + 3, 5000);
    a_in_data  = 32'h12345678;
    a_in_valid = 1'b1;
    @(negedge clk); #1;
    a_in_valid = 1'b0;
    chk("ignored_word_still_busy", 64'(a_busy), 64'(1'b1));
    wait_idle(0, 20000);
    chk("paced_strobes", 64'(nstb[0]), 64'(base + 12));
    busy_cycles[0] = 10;

    // reset in the middle of a word, then a fresh word
    base = nstb[0];
    push_a_word(32'hCAFEF00D);
    offer_a(32'hCAFEF00D);
    wait_strobes(base + 5, 1000);
    rst = 1'b1;
    #1;
    chk("midrst_wr", 64'(a_wr), 64'(1'b0));
    chk("midrst_data", 64'(a_data), 64'(8'h00));
    chk("midrst_busy", 64'(a_busy), 64'(1'b0));
    chk("midrst_ready", 64'(a_in_ready), 64'(1'b0));
    sb_a.delete();
    last_data[0] = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    foreach (ONE_B[i]) sb_a.push_back(ONE_B[i]);
    offer_a(32'h00000001);
    wait_idle(0, 1000);
    chk("after_rst_strobes", 64'(nstb[0]), 64'(base + 5 + 12));

    $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
    $finish;
  end

endmodule
